// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: owns NZCV, drives MEM->EX forwarding and a combinational flags bypass.
// Optional saturating bubble/stall counters are enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage #(
  parameter int WIDTH = 64,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_result,
  input  logic [WIDTH-1:0] ex_wdata,
  input  logic [REGW-1:0]  ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_set_flags,
  input  logic [3:0]       ex_flags_in,
  input  logic             stall,
  input  logic             flush,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [REGW-1:0]  mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [3:0]       flags,
  output logic [3:0]       flags_cur,
  output logic             fwd_en,
  output logic [REGW-1:0]  fwd_rd,
  output logic [WIDTH-1:0] fwd_data
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]      perf_bubbles,
  output logic [31:0]      perf_stalls
`endif
);

  localparam logic [REGW-1:0] XZR = '1;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_wdata;
  logic [REGW-1:0]  r_rd;
  logic             r_reg_write;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [3:0]       r_flags;

  logic w_bubble;
  logic w_load;

  // Flush wins over stall; an idle EX slot also lands as a bubble.
  assign w_bubble = flush | (~stall & ~ex_valid);
  assign w_load   = ~flush & ~stall & ex_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_bubble) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_result    <= ex_result;
      r_wdata     <= ex_wdata;
      r_rd        <= ex_rd;
      r_reg_write <= ex_reg_write & (ex_rd != XZR);
      // A malformed read+write encoding is treated as a store.
      r_mem_read  <= ex_mem_read & ~ex_mem_write;
      r_mem_write <= ex_mem_write;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_load & ex_set_flags) begin
      r_flags <= ex_flags_in;
    end
  end

  assign mem_valid     = r_valid;
  assign mem_result    = r_result;
  assign mem_wdata     = r_wdata;
  assign mem_rd        = r_rd;
  assign mem_reg_write = r_reg_write;
  assign mem_mem_read  = r_mem_read;
  assign mem_mem_write = r_mem_write;
  assign flags         = r_flags;

  // Bypass lets a B.cond right behind a flag-setter see the new NZCV.
  assign flags_cur = (ex_valid & ex_set_flags) ? ex_flags_in : r_flags;

  // Load data is not available until MEM completes, so loads never forward here.
  assign fwd_en   = r_valid & r_reg_write & ~r_mem_read;
  assign fwd_rd   = r_rd;
  assign fwd_data = r_result;

`ifdef EX_MEM_PERF_EN
  logic [31:0] r_perf_bubbles;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_bubbles <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_bubble && (r_perf_bubbles != 32'hFFFF_FFFF)) begin
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
      if (stall && !flush && (r_perf_stalls != 32'hFFFF_FFFF)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign perf_bubbles = r_perf_bubbles;
  assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed table, hand sequences for reset/stall/flush/flags, random vs model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_set_flags;
  logic [63:0] ex_result, ex_wdata;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_flags_in;
  logic        stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, fwd_en;
  logic [63:0] mem_result, mem_wdata, fwd_data;
  logic [4:0]  mem_rd, fwd_rd;
  logic [3:0]  flags, flags_cur;
`ifdef EX_MEM_PERF_EN
  logic [31:0] perf_bubbles, perf_stalls;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.WIDTH(64), .REGW(5)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_set_flags(ex_set_flags), .ex_flags_in(ex_flags_in),
    .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_result(mem_result),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .flags(flags),
    .flags_cur(flags_cur), .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`ifdef EX_MEM_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
`endif
  );

  // Reference state: what the MEM stage should hold, kept as plain fields.
  logic        m_valid, m_rw, m_mr, m_mw;
  logic [63:0] m_result, m_wdata;
  logic [4:0]  m_rd;
  logic [3:0]  m_flags;
  longint      m_bub, m_stl;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
    m_result = 0; m_wdata = 0; m_rd = 0; m_flags = 0; m_bub = 0; m_stl = 0;
  endtask

  task automatic model_edge();
    if (flush || (!stall && !ex_valid)) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_result = 0; m_wdata = 0; m_rd = 0;
      m_bub++;
    end else if (stall) begin
      m_stl++;
    end else begin
      m_valid = 1; m_result = ex_result; m_wdata = ex_wdata; m_rd = ex_rd;
      m_rw = ex_reg_write && (ex_rd != 5'd31);
      m_mw = ex_mem_write;
      m_mr = ex_mem_read && !ex_mem_write;
      if (ex_set_flags) m_flags = ex_flags_in;
    end
  endtask

  task automatic check_model();
    cmp("m.valid", mem_valid, m_valid);
    cmp("m.result", mem_result, m_result);
    cmp("m.wdata", mem_wdata, m_wdata);
    cmp("m.rd", mem_rd, m_rd);
    cmp("m.reg_write", mem_reg_write, m_rw);
    cmp("m.mem_read", mem_mem_read, m_mr);
    cmp("m.mem_write", mem_mem_write, m_mw);
    cmp("m.flags", flags, m_flags);
    cmp("m.fwd_en", fwd_en, m_valid && m_rw && !m_mr);
    cmp("m.fwd_rd", fwd_rd, m_rd);
    cmp("m.fwd_data", fwd_data, m_result);
  endtask

  // Called at a negedge with inputs already driven.
  task automatic tick();
    #1;
    cmp("flags_cur", flags_cur, (ex_valid && ex_set_flags) ? ex_flags_in : m_flags);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [63:0] wd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic sf, input logic [3:0] fl, input logic st, input logic fs);
    ex_valid = v; ex_result = res; ex_wdata = wd; ex_rd = rd; ex_reg_write = rw;
    ex_mem_read = mr; ex_mem_write = mw; ex_set_flags = sf; ex_flags_in = fl;
    stall = st; flush = fs;
  endtask

  typedef struct {
    logic        v, rw, mr, mw, sf, st, fs;
    logic [63:0] res, wd;
    logic [4:0]  rd;
    logic [3:0]  fl;
    logic        e_valid, e_rw, e_mr, e_mw, e_fwd;
    logic [63:0] e_res, e_wd;
    logic [4:0]  e_rd;
    logic [3:0]  e_flags;
  } tv_t;

  tv_t tv [8];

  initial begin
    logic [3:0]  prev_flags;
    logic [63:0] tmp;

    // {inputs} -> {expected registered outputs after one edge}, applied in order from reset
    tv[0] = '{1,1,0,0,0,0,0, 64'h00FF_00FF_00FF_00FF, 64'h5555, 5'd5, 4'h0,
              1,1,0,0,1, 64'h00FF_00FF_00FF_00FF, 64'h5555, 5'd5, 4'h0};
    tv[1] = '{1,1,0,0,0,0,0, 64'h1234, 64'h0, 5'd31, 4'h0,
              1,0,0,0,0, 64'h1234, 64'h0, 5'd31, 4'h0};
    tv[2] = '{1,1,1,0,0,0,0, 64'h40, 64'h0, 5'd3, 4'h0,
              1,1,1,0,0, 64'h40, 64'h0, 5'd3, 4'h0};
    tv[3] = '{1,0,1,1,0,0,0, 64'h80, 64'h77, 5'd7, 4'h0,
              1,0,0,1,0, 64'h80, 64'h77, 5'd7, 4'h0};
    tv[4] = '{1,1,0,0,1,0,0, 64'h0, 64'h0, 5'd9, 4'b0100,
              1,1,0,0,1, 64'h0, 64'h0, 5'd9, 4'b0100};
    tv[5] = '{1,1,0,0,1,1,0, 64'hAAAA, 64'hBBBB, 5'd10, 4'b1001,
              1,1,0,0,1, 64'h0, 64'h0, 5'd9, 4'b0100};
    tv[6] = '{1,1,0,1,1,1,1, 64'hCCCC, 64'hDDDD, 5'd11, 4'b0011,
              0,0,0,0,0, 64'h0, 64'h0, 5'd0, 4'b0100};
    tv[7] = '{0,1,1,0,1,0,0, 64'hEEEE, 64'hFFFF, 5'd12, 4'b1111,
              0,0,0,0,0, 64'h0, 64'h0, 5'd0, 4'b0100};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #12;
    check_model();
    @(negedge clk);
    reset = 1'b0;

    prev_flags = 4'h0;
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].v, tv[i].res, tv[i].wd, tv[i].rd, tv[i].rw, tv[i].mr, tv[i].mw,
            tv[i].sf, tv[i].fl, tv[i].st, tv[i].fs);
      #1;
      cmp($sformatf("tv%0d.flags_cur", i), flags_cur, (tv[i].v && tv[i].sf) ? tv[i].fl : prev_flags);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cmp($sformatf("tv%0d.valid", i), mem_valid, tv[i].e_valid);
      cmp($sformatf("tv%0d.result", i), mem_result, tv[i].e_res);
      cmp($sformatf("tv%0d.wdata", i), mem_wdata, tv[i].e_wd);
      cmp($sformatf("tv%0d.rd", i), mem_rd, tv[i].e_rd);
      cmp($sformatf("tv%0d.reg_write", i), mem_reg_write, tv[i].e_rw);
      cmp($sformatf("tv%0d.mem_read", i), mem_mem_read, tv[i].e_mr);
      cmp($sformatf("tv%0d.mem_write", i), mem_mem_write, tv[i].e_mw);
      cmp($sformatf("tv%0d.flags", i), flags, tv[i].e_flags);
      cmp($sformatf("tv%0d.fwd_en", i), fwd_en, tv[i].e_fwd);
      cmp($sformatf("tv%0d.fwd_data", i), fwd_data, tv[i].e_res);
      prev_flags = tv[i].e_flags;
    end

    // Async reset mid-cycle with the stage loaded
    drive(1, 64'hDEAD, 64'h1, 5'd4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    cmp("pre_reset.result", mem_result, 64'hDEAD);
    #2 reset = 1'b1;
    #1;
    model_reset();
    cmp("rst.result", mem_result, 64'h0);
    cmp("rst.valid", mem_valid, 1'b0);
    cmp("rst.rd", mem_rd, 5'd0);
    cmp("rst.reg_write", mem_reg_write, 1'b0);
    cmp("rst.flags", flags, 4'h0);
    @(posedge clk);
    #1;
    cmp("rst_held.valid", mem_valid, 1'b0);
    cmp("rst_held.result", mem_result, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Three stalled cycles with changing inputs must leave the stage untouched
    drive(1, 64'h0123_4567_89AB_CDEF, 64'h42, 5'd6, 1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tmp = {$urandom, $urandom};
      drive(1, tmp, tmp, 5'(i + 20), 0, 1, 1, 1, 4'hF, 1, 0);
      tick();
      cmp("stall.result", mem_result, 64'h0123_4567_89AB_CDEF);
      cmp("stall.rd", mem_rd, 5'd6);
      cmp("stall.flags", flags, 4'h0);
    end
    drive(1, 64'h99, 64'h99, 5'd8, 1, 1, 0, 0, 0, 1, 1);
    tick();
    cmp("stall_flush.valid", mem_valid, 1'b0);
    cmp("stall_flush.ctl", {mem_reg_write, mem_mem_read, mem_mem_write}, 3'b000);

    // Flag setter under stall, then under flush: NZCV must not move, bypass still shows it
    drive(1, 0, 0, 5'd2, 1, 0, 0, 1, 4'b0100, 1, 0);
    #1 cmp("ands_stall.flags_cur", flags_cur, 4'b0100);
    tick();
    cmp("ands_stall.flags", flags, 4'h0);
    drive(1, 0, 0, 5'd2, 1, 0, 0, 1, 4'b0100, 0, 1);
    tick();
    cmp("ands_flush.flags", flags, 4'h0);
    drive(1, 0, 0, 5'd2, 1, 0, 0, 1, 4'b0100, 0, 0);
    tick();
    cmp("ands.flags", flags, 4'b0100);

`ifdef EX_MEM_PERF_EN
    begin
      longint b0, s0;
      b0 = perf_bubbles; s0 = perf_stalls;
      for (int i = 0; i < 2; i++) begin drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1); tick(); end
      for (int i = 0; i < 3; i++) begin drive(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 4; i++) begin drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0); tick(); end
      cmp("perf.bubbles", perf_bubbles - 32'(b0), 32'd5);
      cmp("perf.stalls", perf_stalls - 32'(s0), 32'd4);
      force dut.r_perf_stalls = 32'hFFFF_FFFF;
      #1 release dut.r_perf_stalls;
      drive(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0);
      tick();
      cmp("perf.stall_sat", perf_stalls, 32'hFFFF_FFFF);
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom}, rd,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary of the pipelined 64-bit CPU, directly downstream of the ALU (and/or/add/sub slices).
- Registers the ALU result, store data, destination register and memory/writeback controls for the MEM stage.
- Owns the architectural NZCV flags register, written by flag-setting instructions.
- Drives the EX-stage forwarding path and a combinational flags bypass for conditional branches.

Parameters:
WIDTH, 64, datapath width of result and store data
REGW, 5, register-index width; index 2**REGW-1 (X31) is XZR

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
ex_valid  input  1  EX stage holds a real instruction
ex_result  input  WIDTH  ALU result
ex_wdata  input  WIDTH  store data (Rt value)
ex_rd  input  REGW  destination register
ex_reg_write  input  1  instruction writes the register file
ex_mem_read  input  1  load
ex_mem_write  input  1  store
ex_set_flags  input  1  instruction updates NZCV (ADDS/SUBS/ANDS)
ex_flags_in  input  4  ALU flags {N,Z,C,V}
stall  input  1  hold stage contents
flush  input  1  squash the incoming instruction (insert bubble)
mem_valid  output  1  registered valid
mem_result  output  WIDTH  registered ALU result
mem_wdata  output  WIDTH  registered store data
mem_rd  output  REGW  registered destination
mem_reg_write  output  1  registered regwrite
mem_mem_read  output  1  registered load
mem_mem_write  output  1  registered store
flags  output  4  architectural NZCV register
flags_cur  output  4  combinational flags for B.cond in EX
fwd_en  output  1  forwarding from MEM stage is valid
fwd_rd  output  REGW  forwarding register index
fwd_data  output  WIDTH  forwarding value (= mem_result)

Behaviour:
- Reset (async, immediate): all mem_* outputs 0, flags = 4'b0000. Outputs remain 0 while reset is held. Reset mid-stall or mid-flush discards everything.
- Edge priority: flush > stall > load.
- flush=1: capture a bubble. mem_valid, mem_reg_write, mem_mem_read and mem_mem_write = 0; mem_result, mem_wdata and mem_rd = 0. Flags are not updated. Flush overrides a simultaneous stall.
- stall=1 (flush=0): every register, including flags, holds its value.
- Load (stall=0, flush=0), latency 1 cycle:
  - ex_valid=0: capture a bubble, same values as flush.
  - ex_valid=1: capture all fields.
- Capture rules when ex_valid=1:
  - mem_reg_write = ex_reg_write & (ex_rd != 2**REGW-1); writes to XZR are dropped.
  - If ex_mem_read and ex_mem_write are both 1: mem_mem_write = 1, mem_mem_read = 0.
- Flags update: flags <= ex_flags_in on an edge with ex_valid & ex_set_flags & !stall & !flush. Otherwise flags hold.
- flags_cur = (ex_valid & ex_set_flags) ? ex_flags_in : flags. Purely combinational, so a B.cond directly after a flag-setter sees the new flags.
- fwd_en = mem_valid & mem_reg_write & !mem_mem_read. Loads are not forwardable from this stage; the hazard unit stalls for them.
- fwd_rd = mem_rd; fwd_data = mem_result.
- No arithmetic is performed; widths pass through unchanged.

Optional Feature:
Macro EX_MEM_PERF_EN.
- Defined:
  - Adds outputs perf_bubbles (32-bit) and perf_stalls (32-bit), both reset to 0.
  - perf_bubbles increments on each edge that captures a bubble (flush, or load with ex_valid=0).
  - perf_stalls increments on each edge with stall=1 & flush=0.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset mid-cycle with stage loaded (mem_result=64'hDEAD) -> all mem_* outputs and flags become 0 before the next edge.
- Load: ex_valid=1, ex_result=64'h00FF_00FF_00FF_00FF, ex_rd=5, ex_reg_write=1 -> next edge: mem_result=64'h00FF00FF00FF00FF, mem_rd=5, fwd_en=1, fwd_data equals mem_result.
- XZR and load forwarding:
  - ex_rd=31, ex_reg_write=1 -> mem_reg_write=0, fwd_en=0.
  - ex_mem_read=1, ex_rd=3 -> mem_mem_read=1, fwd_en=0.
- Stall then flush:
  - Loaded stage with stall=1 for 3 cycles and new ex_* values -> outputs unchanged.
  - stall=1 and flush=1 together -> next edge: mem_valid=0 and all controls 0.
- Flags:
  - ANDS with ex_flags_in=4'b0100 -> flags_cur=4'b0100 in the same cycle; flags=4'b0100 after the edge.
  - Same instruction with stall=1 -> flags unchanged, flags_cur=4'b0100.
  - Same instruction with flush=1 -> flags unchanged.
- Perf counters (EX_MEM_PERF_EN defined):
  - 2 flushes, 3 ex_valid=0 loads, 4 stalls -> perf_bubbles=5, perf_stalls=4.
  - Preload perf_stalls to 32'hFFFFFFFF, then stall -> perf_stalls stays 32'hFFFFFFFF.
